// File: rtl/lsu_bus.sv
// rtl/lsu_bus.sv - load/store unit driving a single-outstanding valid/ready data-memory port
//
// Purpose:
//   Accepts one load or store request from the multicycle controller and runs
//   it over the data-memory port. Stores get byte enables and lane-replicated
//   write data. Loads get the addressed byte/halfword shifted down to bit 0 so
//   the downstream extender can work on result[7:0] / result[15:0] directly.
//
// Parameters:
//   TIMEOUT        max cycles waiting on mem_ready before abort (0 = no timeout)
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses skip the
//                         bus and complete immediately with err = misaligned = 1.
//                         When undefined, low address bits below the access size
//                         are ignored and misaligned is tied 0.
//
// Ports:
//   clk            in   1   clock, rising edge
//   reset          in   1   asynchronous active-high reset
//   start          in   1   request strobe, sampled only in IDLE
//   memwrite       in   1   1 = store, 0 = load
//   size           in   2   00 byte, 01 half, 10/11 word
//   addr           in   32  byte address
//   wdata          in   32  store data
//   busy           out  1   high in every state except IDLE
//   done           out  1   one-cycle completion pulse
//   err            out  1   timeout or misalign abort, valid with done
//   misaligned     out  1   misalign abort, valid with done
//   rdata_aligned  out  32  lane-shifted load data
//   mem_req        out  1   bus request
//   mem_we         out  1   bus write
//   mem_addr       out  32  word-aligned bus address
//   mem_wdata      out  32  lane-replicated store data
//   mem_be         out  4   byte enables
//   mem_ready      in   1   bus accept/complete
//   mem_rdata      in   32  bus read data, valid with mem_ready

module lsu_bus #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        misaligned,
  output logic [31:0] rdata_aligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  // Wait counter wide enough to hold TIMEOUT itself (it saturates there).
  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO_MAX  = WW'(TIMEOUT);
  localparam logic [WW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          mis_q;
  logic          req_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   rdata_q;
  logic [1:0]    size_q;
  logic [1:0]    lo_q;
  logic [WW-1:0] wait_q;

  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic [31:0]   rdata_d;
  logic [31:0]   rsh_b;
  logic [31:0]   rsh_h;
  logic          mis_w;

  // Misalignment detection only exists in the trapping build.
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_w = ((size == 2'b01) && addr[0]) ||
                 (size[1] && (addr[1:0] != 2'b00));
`else
  assign mis_w = 1'b0;
`endif

  // Byte enables and write lanes are formed from the live request inputs and
  // captured on acceptance, so they stay stable through the whole REQ phase.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata;
    unique case (size)
      2'b00: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {addr[1], 1'b0};
        wdata_d = {2{wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = wdata;
      end
    endcase
  end

  // Load alignment uses the latched size/offset since the request inputs are
  // free to change once the access is accepted.
  always_comb begin
    rsh_b   = mem_rdata >> {lo_q, 3'b000};
    rsh_h   = mem_rdata >> {lo_q[1], 4'b0000};
    rdata_d = mem_rdata;
    unique case (size_q)
      2'b00:   rdata_d = {24'h000000, rsh_b[7:0]};
      2'b01:   rdata_d = {16'h0000, rsh_h[15:0]};
      default: rdata_d = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      lo_q    <= '0;
      wait_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          mis_q  <= 1'b0;
          if (start) begin
            size_q  <= size;
            lo_q    <= addr[1:0];
            addr_q  <= {addr[31:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            wait_q  <= '0;
            busy_q  <= 1'b1;
            if (mis_w) begin
              // Trapped access never touches the bus.
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              mis_q   <= 1'b1;
            end else begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
              we_q    <= memwrite;
            end
          end
        end

        S_REQ: begin
          if (mem_ready) begin
            // we_q still holds the access direction at this edge.
            if (!we_q) begin
              rdata_q <= rdata_d;
            end
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            state_q <= S_DONE;
          end else if ((TIMEOUT != 0) && (wait_q == TO_LAST)) begin
            // This cycle completes TIMEOUT request cycles without a response.
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            wait_q  <= TO_MAX;
            state_q <= S_DONE;
          end else if (wait_q != TO_MAX) begin
            wait_q <= wait_q + 1'b1;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          mis_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          mis_q   <= 1'b0;
          busy_q  <= 1'b0;
          req_q   <= 1'b0;
          we_q    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign misaligned    = mis_q;
  assign rdata_aligned = rdata_q;
  assign mem_req       = req_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_be        = be_q;

endmodule

// File: tb/tb_lsu_bus.sv
// tb/tb_lsu_bus.sv - randomized self-checking bench for lsu_bus against a behavioural model

module tb_lsu_bus;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        memwrite;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        misaligned;
  logic [31:0] rdata_aligned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_bus #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .memwrite      (memwrite),
    .size          (size),
    .addr          (addr),
    .wdata         (wdata),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .misaligned    (misaligned),
    .rdata_aligned (rdata_aligned),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_rdata = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
  endtask

  function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    if (sz == 2'd1) return (a % 2) != 0;
    if (sz >= 2'd2) return (a % 4) != 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'(1 << (a % 4));
    if (sz == 2'd1) return 4'(3 << (2 * ((a / 2) % 2)));
    return 4'd15;
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'd0) return (w & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] model_align(input logic [1:0] sz, input logic [31:0] a,
                                              input logic [31:0] r);
    if (sz == 2'd0) return (r >> (8 * (a % 4))) & 32'hFF;
    if (sz == 2'd1) return (r >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    return r;
  endfunction

  // One full transaction; wait_n = cycles mem_ready stays low (>= TO means never).
  task automatic txn(input bit we, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd,
                     input int wait_n, input bit poke);
    bit mis;
    bit ok;
    int last;
    @(negedge clk);
    memwrite = we; size = sz; addr = a; wdata = wd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble request inputs: the DUT must have latched everything.
    memwrite = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
    mis = model_mis(sz, a);
    if (mis) begin
      chk("mis_done", done, 1);
      chk("mis_err", err, 1);
      chk("mis_flag", misaligned, 1);
      chk("mis_noreq", mem_req, 0);
      chk("mis_rdata", rdata_aligned, exp_rdata);
    end else begin
      ok   = (wait_n < TO);
      last = ok ? wait_n + 1 : TO;
      for (int c = 1; c <= last; c++) begin
        chk("req", mem_req, 1);
        chk("busy", busy, 1);
        chk("req_done", done, 0);
        chk("we", mem_we, we);
        chk("addr", mem_addr, a & ~32'd3);
        chk("be", mem_be, model_be(sz, a));
        if (we) chk("wdata", mem_wdata, model_wd(sz, wd));
        mem_ready = ok && (c == last);
        mem_rdata = (c == last) ? rd : $urandom;
        @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (ok && !we) exp_rdata = model_align(sz, a, rd);
      chk("done", done, 1);
      chk("err", err, !ok);
      chk("misflag", misaligned, 0);
      chk("req_off", mem_req, 0);
      chk("rdata", rdata_aligned, exp_rdata);
    end
    // DONE cycle: start and mem_ready here must be ignored.
    if (poke) begin
      start = 1'b1; mem_ready = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0; mem_ready = 1'b0;
    chk("pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_req", mem_req, 0);
    chk("hold_rdata", rdata_aligned, exp_rdata);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; memwrite = 1'b0; size = 2'd0; addr = '0; wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mis", misaligned, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_rdata", rdata_aligned, 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases
    txn(1'b0, 2'd0, 32'h0000_1003, 32'h0, 32'hA1B2_C3D4, 0, 1'b0);
    txn(1'b1, 2'd1, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 0, 1'b1);
    txn(1'b0, 2'd2, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 3, 1'b0);
    txn(1'b0, 2'd2, 32'h0000_0200, 32'h0, 32'h1111_2222, 100, 1'b0);
    txn(1'b0, 2'd2, 32'h0000_3001, 32'h0, 32'h5566_7788, 0, 1'b0);
    txn(1'b0, 2'd3, 32'h0000_0302, 32'h0, 32'h99AA_BBCC, 1, 1'b1);

    // Reset in the middle of REQ, with start re-pulsed while busy
    @(negedge clk);
    memwrite = 1'b0; size = 2'd2; addr = 32'h0000_4000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rq_req", mem_req, 1);
    @(negedge clk);
    start = 1'b1; memwrite = 1'b1; addr = 32'h5555_0000;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rp_req", mem_req, 1);
    chk("rp_addr", mem_addr, 32'h0000_4000);
    chk("rp_we", mem_we, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rdata", rdata_aligned, 0);
    exp_rdata = 32'h0;
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("arst_nodone", done, 0);
      chk("arst_noreq", mem_req, 0);
    end
    mem_ready = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
          int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu_bus.md
# lsu_bus

Multicycle-core load/store unit that sits directly upstream of the load-data extender. Takes one load or store request from the controller and runs it over a single-outstanding valid/ready data-memory port. For loads, it captures the returned word and shifts the addressed byte/halfword down to bit 0, so the extender can zero- or sign-extend `result[7:0]` or `result[15:0]` directly. For stores, it generates byte enables and lane-replicated write data.

## Interface
Parameters:
- `TIMEOUT`, 255: max cycles waiting on `mem_ready` before abort; 0 disables the timeout.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request strobe; sampled only in IDLE.
- `memwrite`  in  1  1 = store, 0 = load.
- `size`  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data (rs2).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`: timeout or misalign abort.
- `misaligned`  out  1  valid with `done` (macro build only; tied 0 otherwise).
- `rdata_aligned`  out  32  lane-shifted load data; feeds the extender's `result` input.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  bus write.
- `mem_addr`  out  32  `{addr[31:2],2'b00}`.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_be`  out  4  byte enables.
- `mem_ready`  in  1  bus accept/complete.
- `mem_rdata`  in  32  bus read data, valid with `mem_ready`.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE → REQ on `start`. In the same edge, latch `memwrite`, `size`, `addr[1:0]` and the lane-formatted write data.
- REQ: `mem_req` = 1 and all `mem_*` outputs are held stable.
  - `mem_ready` = 1 → DONE. On a load, register `rdata_aligned` at the same edge.
  - Wait counter reaches `TIMEOUT` with `TIMEOUT` ≠ 0 → DONE with `err` = 1; `rdata_aligned` is left unchanged.
- DONE: `done` = 1 for one cycle, then → IDLE.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << {addr[1],1'b0}`
  - word: `4'b1111`
  - Loads drive the same `mem_be`.
- Write data:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: `wdata`
- Load alignment:
  - byte: `mem_rdata >> (8*addr[1:0])`, bits [31:8] zeroed.
  - half: `mem_rdata >> (16*addr[1])`, bits [31:16] zeroed.
  - word: unchanged.
- `rdata_aligned` holds its value until the next successful load.
- `start` while busy: ignored, no queueing.
- The wait counter clears on entry to REQ and saturates at `TIMEOUT`.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `misaligned`, `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `mem_be`, `rdata_aligned` = 0.
- Reset is asynchronous. Asserting `reset` mid-REQ drops `mem_req` immediately and discards the access. No `done` pulse is produced.
- Latency: `start` at edge N → `mem_req` high from N+1. If `mem_ready` is high in the first REQ cycle, `done` is high in cycle N+2. Each wait cycle adds 1.
- Minimum issue interval: 3 cycles (next `start` accepted in the cycle after `done`).
- Timeout: `err`/`done` assert in the cycle after `mem_req` has been high `TIMEOUT` cycles without `mem_ready`.
- `mem_ready` outside REQ is ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A half access with `addr[0]` = 1, or a word access with `addr[1:0]` ≠ 0, skips REQ. IDLE → DONE directly, with `misaligned` = 1 and `err` = 1.
  - `mem_req` never asserts for that access.
- Undefined:
  - No check is made. The address low bits below the access size are ignored: half uses `addr[1]` only, word uses `mem_be` = 1111.
  - `misaligned` is tied 0.

## Test plan
- Load byte, `addr` = 0x1003, `mem_rdata` = 0xA1B2C3D4, ready in the first cycle → `mem_be` = 1000, `rdata_aligned` = 0x000000A1, `done` 2 cycles after `start`.
- Store half, `addr` = 0x2002, `wdata` = 0x1234ABCD → `mem_be` = 1100, `mem_wdata` = 0xABCDABCD, `mem_we` = 1, `mem_addr` = 0x2000.
- Load word, `mem_ready` held low 3 cycles → `mem_req` stable for 4 cycles, `rdata_aligned` = `mem_rdata`, `done` single pulse.
- `TIMEOUT` = 4, `mem_ready` never asserts → `done` = 1, `err` = 1 after 4 request cycles; `rdata_aligned` keeps its prior value.
- Word load at `addr` = 0x3001: with macro → `misaligned` = 1, `err` = 1, no `mem_req`; without macro → `mem_be` = 1111, `mem_addr` = 0x3000, `err` = 0.
- `reset` pulsed during REQ, `start` re-pulsed while busy → `mem_req` drops asynchronously, no `done`; the re-pulsed `start` is ignored.
